// File: rtl/serial_word_collector.sv
// Serial-in, parallel-out word collector: LSB-first bits into BITS-wide words,
// presented on a valid/ready holding register with sticky framing/overrun flags.
module serial_word_collector #(
    parameter int BITS = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            SI,
    input  logic            En,
    input  logic            Sync,
    input  logic            Ready,
    input  logic            Clr,
    output logic [BITS-1:0] Data,
    output logic            Valid,
    output logic            Overrun,
    output logic            FrameErr,
    output logic            Busy
);

    localparam int CW = $clog2(BITS + 1);

    if (BITS < 2) begin : g_bits_check
        $error("serial_word_collector: BITS must be >= 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic            ferr_q, ferr_d;

    logic            last_bit;
    logic            done;
    logic            ferr_set;
    logic            ovr_set;
    logic [BITS-1:0] word;

    assign word     = {SI, sr_q[BITS-1:1]};
    assign last_bit = (cnt_q == CW'(BITS - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (En && Sync) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (En && !Sync && last_bit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == SHIFT);
    end

    // Shift register, bit counter and word-completion detection
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        done     = 1'b0;
        ferr_set = 1'b0;
        if (En) begin
            if (Sync) begin
                sr_d     = {SI, {(BITS-1){1'b0}}};
                cnt_d    = CW'(1);
                ferr_set = (state_q == SHIFT);
            end else if (state_q == SHIFT) begin
                sr_d = word;
                if (last_bit) begin
                    cnt_d = '0;
                    done  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Holding register; a consumed slot may be refilled in the same cycle
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_set = 1'b0;
        if (done) begin
            if (!valid_q || Ready) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (valid_q && Ready) begin
            valid_d = 1'b0;
        end
        ovr_d  = ovr_set | (ovr_q & ~Clr);
        ferr_d = ferr_set | (ferr_q & ~Clr);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign Data     = data_q;
    assign Valid    = valid_q;
    assign Overrun  = ovr_q;
    assign FrameErr = ferr_q;

endmodule
